// File: rtl/alu_op_sequencer_if.sv
// Command and response channels of the ALU op sequencer.
// master = command source / result consumer, slave = sequencer.
interface alu_op_sequencer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [3:0]            cmd_fun;
  logic [DATA_WIDTH-1:0] cmd_a;
  logic [DATA_WIDTH-1:0] cmd_b;
  logic                  res_valid;
  logic                  res_ready;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  res_flag;
  logic [3:0]            res_fun;

  modport master (
    output cmd_valid, cmd_fun, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_data, res_flag, res_fun
  );

  modport slave (
    input  cmd_valid, cmd_fun, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_valid, res_data, res_flag, res_fun
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// ALU command front-end: latches one op, pulses one unit enable, captures result and flag.
// Optional ALU_SEQ_OVERLAP_EN: accept the next command on the result handshake edge.
//
// state   | meaning
// IDLE    | waiting for a command (cmd_ready=1)
// EXEC    | one-hot unit enable high for one cycle; flag sampled at closing edge
// CAPTURE | enables low; selected unit's registered result captured
// RESP    | res_valid high until res_ready
module alu_op_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int SEL_LINE   = 2
) (
  input  logic                  clk,
  input  logic                  async_rst,
  alu_op_sequencer_if.slave     bus,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] B,
  output logic [SEL_LINE-1:0]   ALU_FUN,
  output logic                  ARITH_Enable,
  output logic                  LOGIC_Enable,
  output logic                  CMP_Enable,
  output logic                  SHIFT_Enable,
  input  logic [DATA_WIDTH-1:0] ARITH_OUT,
  input  logic [DATA_WIDTH-1:0] LOGIC_OUT,
  input  logic [DATA_WIDTH-1:0] CMP_OUT,
  input  logic [DATA_WIDTH-1:0] SHIFT_OUT,
  input  logic [3:0]            unit_flags
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [SEL_LINE-1:0]   r_alu_fun;
  logic [3:0]            r_en;
  logic [DATA_WIDTH-1:0] r_res_data;
  logic                  r_res_flag;
  logic [3:0]            r_res_fun;
  logic                  r_res_valid;

  logic                  w_cmd_ready;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_unit_out;

`ifdef ALU_SEQ_OVERLAP_EN
  assign w_cmd_ready = (r_state == IDLE) | ((r_state == RESP) & bus.res_ready);
`else
  assign w_cmd_ready = (r_state == IDLE);
`endif

  assign w_accept = bus.cmd_valid & w_cmd_ready;

  always_comb begin
    w_unit_out = '0;
    case (r_res_fun[3:2])
      2'b00:   w_unit_out = ARITH_OUT;
      2'b01:   w_unit_out = LOGIC_OUT;
      2'b10:   w_unit_out = CMP_OUT;
      default: w_unit_out = SHIFT_OUT;
    endcase
  end

  always_ff @(posedge clk or negedge async_rst) begin
    if (!async_rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_alu_fun   <= '0;
      r_en        <= '0;
      r_res_data  <= '0;
      r_res_flag  <= 1'b0;
      r_res_fun   <= '0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: ;
        EXEC: begin
          r_en       <= '0;
          r_res_flag <= unit_flags[r_res_fun[3:2]];
          r_state    <= CAPTURE;
        end
        CAPTURE: begin
          r_res_data  <= w_unit_out;
          r_res_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
      // An accept overrides the RESP exit when overlap is enabled.
      if (w_accept) begin
        r_a       <= bus.cmd_a;
        r_b       <= bus.cmd_b;
        r_alu_fun <= SEL_LINE'(bus.cmd_fun[1:0]);
        r_res_fun <= bus.cmd_fun;
        r_en      <= 4'b0001 << bus.cmd_fun[3:2];
        r_state   <= EXEC;
      end
    end
  end

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.res_flag  = r_res_flag;
  assign bus.res_fun   = r_res_fun;

  assign A            = r_a;
  assign B            = r_b;
  assign ALU_FUN      = r_alu_fun;
  assign ARITH_Enable = r_en[0];
  assign LOGIC_Enable = r_en[1];
  assign CMP_Enable   = r_en[2];
  assign SHIFT_Enable = r_en[3];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural shift unit and constant stub units.
module tb_alu_op_sequencer;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          async_rst = 1'b0;
  logic [DW-1:0] A, B;
  logic [1:0]    ALU_FUN;
  logic          ARITH_Enable, LOGIC_Enable, CMP_Enable, SHIFT_Enable;
  logic [DW-1:0] ARITH_OUT, LOGIC_OUT, CMP_OUT, SHIFT_OUT;
  logic [3:0]    unit_flags;
  logic [DW-1:0] shift_reg = '0;
  logic          use_stubs = 1'b0;
  logic [3:0]    flag_pat = 4'b1111;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          flag;
    logic [3:0]    fun;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  alu_op_sequencer_if #(.DATA_WIDTH(DW)) bus ();

  alu_op_sequencer #(.DATA_WIDTH(DW), .SEL_LINE(2)) dut (
    .clk(clk), .async_rst(async_rst), .bus(bus),
    .A(A), .B(B), .ALU_FUN(ALU_FUN),
    .ARITH_Enable(ARITH_Enable), .LOGIC_Enable(LOGIC_Enable),
    .CMP_Enable(CMP_Enable), .SHIFT_Enable(SHIFT_Enable),
    .ARITH_OUT(ARITH_OUT), .LOGIC_OUT(LOGIC_OUT),
    .CMP_OUT(CMP_OUT), .SHIFT_OUT(SHIFT_OUT),
    .unit_flags(unit_flags)
  );

  always #5 clk = ~clk;

  // Shift unit: registered result, flag valid only while enabled.
  always @(posedge clk) begin
    if (SHIFT_Enable) begin
      case (ALU_FUN)
        2'b00:   shift_reg <= A >> 1;
        2'b01:   shift_reg <= A << 1;
        2'b10:   shift_reg <= B >> 1;
        default: shift_reg <= B << 1;
      endcase
    end
  end

  assign ARITH_OUT  = 16'h1111;
  assign LOGIC_OUT  = 16'h2222;
  assign CMP_OUT    = 16'h3333;
  assign SHIFT_OUT  = use_stubs ? 16'h4444 : shift_reg;
  assign unit_flags = {SHIFT_Enable, CMP_Enable, LOGIC_Enable, ARITH_Enable} & flag_pat;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] en_vec();
    return {SHIFT_Enable, CMP_Enable, LOGIC_Enable, ARITH_Enable};
  endfunction

  task automatic check_result(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s: result with empty scoreboard got 0x%0h expected none", tag, bus.res_data);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_data"}, 32'(bus.res_data), 32'(e.data));
      check({tag, "_flag"}, 32'(bus.res_flag), 32'(e.flag));
      check({tag, "_fun"},  32'(bus.res_fun),  32'(e.fun));
    end
  endtask

  // Full single op with timing checks; hold = cycles of res_ready=0 in RESP.
  task automatic run_op(input string tag, input logic [3:0] fun, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] exp_data,
                        input logic exp_flag, input int hold);
    int guard;
    logic [DW-1:0] held_data;
    logic          held_flag;
    bus.cmd_fun   = fun;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_valid = 1'b1;
    guard = 0;
    while (!bus.cmd_ready && guard < 20) begin
      tick();
      guard++;
    end
    check({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    sb.push_back('{data: exp_data, flag: exp_flag, fun: fun});
    check({tag, "_en_exec"}, 32'(en_vec()), 32'(4'b0001 << fun[3:2]));
    check({tag, "_latch_a"}, 32'(A), 32'(a));
    check({tag, "_latch_b"}, 32'(B), 32'(b));
    check({tag, "_alu_fun"}, 32'(ALU_FUN), 32'(fun[1:0]));
    tick();
    check({tag, "_en_capture"}, 32'(en_vec()), 32'd0);
    check({tag, "_valid_early"}, 32'(bus.res_valid), 32'd0);
    tick();
    check({tag, "_valid_n2"}, 32'(bus.res_valid), 32'd1);
    check_result(tag);
    held_data = bus.res_data;
    held_flag = bus.res_flag;
    for (int i = 0; i < hold; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_a     = 16'h1234;
      bus.cmd_b     = 16'h5678;
      tick();
      check({tag, "_bp_valid"}, 32'(bus.res_valid), 32'd1);
      check({tag, "_bp_data"},  32'(bus.res_data),  32'(held_data));
      check({tag, "_bp_flag"},  32'(bus.res_flag),  32'(held_flag));
      check({tag, "_bp_ready"}, 32'(bus.cmd_ready), 32'd0);
      check({tag, "_bp_a"},     32'(A),             32'(a));
      check({tag, "_bp_en"},    32'(en_vec()),      32'd0);
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check({tag, "_valid_clr"}, 32'(bus.res_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    int acc_t[2];
    int n_acc, n_res;
    logic acc, hs;

    bus.cmd_valid = 1'b0;
    bus.cmd_fun   = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.res_ready = 1'b0;
    #23 async_rst = 1'b1;
    tick();

    check("rst_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_valid", 32'(bus.res_valid), 32'd0);
    check("rst_data",  32'(bus.res_data),  32'd0);
    check("rst_fun",   32'(bus.res_fun),   32'd0);
    check("rst_en",    32'(en_vec()),      32'd0);
    check("rst_a",     32'(A),             32'd0);

    // Reset during EXEC drops the operation.
    bus.cmd_fun   = 4'b1100;
    bus.cmd_a     = 16'h0006;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    check("midop_shift_en", 32'(SHIFT_Enable), 32'd1);
    #2 async_rst = 1'b0;
    #1;
    check("midop_en_drop", 32'(en_vec()),      32'd0);
    check("midop_valid",   32'(bus.res_valid), 32'd0);
    check("midop_data",    32'(bus.res_data),  32'd0);
    check("midop_a",       32'(A),             32'd0);
    #10 async_rst = 1'b1;
    tick();
    check("midop_ready_after", 32'(bus.cmd_ready), 32'd1);
    tick();
    check("midop_no_result", 32'(bus.res_valid), 32'd0);

    // Shift paths through the behavioural shift unit.
    run_op("shr_a", 4'b1100, 16'h0006, 16'h0000, 16'h0003, 1'b1, 0);
    run_op("shl_a", 4'b1101, 16'h0006, 16'h0000, 16'h000C, 1'b1, 0);
    run_op("shr_b", 4'b1110, 16'hFFFF, 16'h8000, 16'h4000, 1'b1, 0);

    // Backpressure with a competing command pulsed meanwhile.
    flag_pat = 4'b0111;
    run_op("bp", 4'b1111, 16'h0000, 16'h0003, 16'h0006, 1'b0, 10);

    // Unit select sweep with stub outputs and a mixed flag pattern.
    use_stubs = 1'b1;
    flag_pat  = 4'b0101;
    for (int s = 0; s < 4; s++) begin
      logic [1:0] sel;
      sel = 2'(s);
      run_op("sweep", {sel, 2'b01}, 16'(s + 16'h10), 16'(s + 16'h20),
             16'(16'h1111 * (s + 1)), flag_pat[sel], 0);
    end

    // Back-to-back spacing with cmd_valid and res_ready held high.
    use_stubs     = 1'b0;
    flag_pat      = 4'b1111;
    bus.cmd_fun   = 4'b1100;
    bus.cmd_a     = 16'h0006;
    bus.cmd_b     = 16'h0000;
    bus.cmd_valid = 1'b1;
    bus.res_ready = 1'b1;
    n_acc = 0;
    n_res = 0;
    acc_t[0] = 0;
    acc_t[1] = 0;
    for (int c = 0; c < 30 && n_res < 2; c++) begin
      acc = bus.cmd_valid & bus.cmd_ready;
      hs  = bus.res_valid & bus.res_ready;
      if (hs) begin
        check_result("b2b");
        n_res++;
      end
      tick();
      if (acc) begin
        sb.push_back('{data: 16'h0003, flag: 1'b1, fun: 4'b1100});
        acc_t[n_acc] = c;
        n_acc++;
        if (n_acc == 2) bus.cmd_valid = 1'b0;
      end
    end
    bus.res_ready = 1'b0;
    check("b2b_results", 32'(n_res), 32'd2);
`ifdef ALU_SEQ_OVERLAP_EN
    check("b2b_spacing", 32'(acc_t[1] - acc_t[0]), 32'd3);
`else
    check("b2b_spacing", 32'(acc_t[1] - acc_t[0]), 32'd4);
`endif
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
